dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port (12-bit address, 32-bit data, 2-bit access mode, write enable) between the CPU load/store path and a read-only debug requester (LED/probe display engine, host monitor).
- CPU has priority by default; a bounded-wait counter guarantees debug service.
- Sits between the CPU datapath (ALU result as address, rt data as write data) and the RAM; asserts a stall that the CPU ANDs into its PC enable.

Parameters:
- AW, 12, memory address width (byte address).
- DW, 32, data width.
- MAXWAIT, 4, maximum cycles a pending debug request waits behind CPU traffic; legal range 1..15.

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU memory access this cycle (load or store)
- cpu_we  in  1  CPU store
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_mode  in  2  CPU access size/mode, passed through
- cpu_rdata  out  DW  load data to CPU (combinational from ram_rdata)
- cpu_stall  out  1  CPU must hold PC and suppress register write this cycle
- dbg_req  in  1  debug read request, level, held until ack
- dbg_addr  in  AW  debug address, stable while dbg_req high
- dbg_ack  out  1  one-cycle pulse, dbg_rdata valid
- dbg_rdata  out  DW  registered debug read data
- ram_addr  out  AW  to RAM
- ram_wdata  out  DW  to RAM
- ram_mode  out  2  to RAM
- ram_we  out  1  to RAM (synchronous write)
- ram_rdata  in  DW  from RAM (asynchronous read)
- stat_stall_cnt  out  32  stall-cycle count (feature only)
- stat_dbg_cnt  out  32  debug-grant count (feature only)

Behaviour:
- States: IDLE, WAIT, GRANT, ACK. Registered state plus wait counter cnt, width clog2(MAXWAIT+1).
- IDLE:
  - dbg_req & !cpu_req -> GRANT.
  - dbg_req & cpu_req -> WAIT, cnt=1.
  - Otherwise stay.
- WAIT:
  - !dbg_req -> IDLE (abort, no ack).
  - !cpu_req or cnt==MAXWAIT -> GRANT.
  - Otherwise cnt+1.
- GRANT:
  - ram_addr=dbg_addr, ram_mode=2'b00 (word), ram_we=0.
  - cpu_stall=cpu_req.
  - dbg_rdata<=ram_rdata at clock edge; -> ACK.
- ACK: dbg_ack=1 for exactly one cycle; -> IDLE; cnt=0.
- Outside GRANT: ram_addr/wdata/mode=cpu_*, ram_we=cpu_req&cpu_we, cpu_stall=0.
- Stores are never issued during GRANT. A stalled CPU re-presents the same access next cycle and completes then.
- Latency, debug request to ack:
  - 2 cycles when CPU idle.
  - At most MAXWAIT+2 cycles under continuous CPU traffic.
- CPU stall: at most 1 cycle per debug transaction.
- dbg_req must drop in the cycle dbg_ack is high. If still high in IDLE, it is a new transaction.
- dbg_req falling during GRANT: read still completes and ack is still pulsed; the requester ignores it.
- cpu_rdata is always ram_rdata; it is only meaningful when cpu_stall=0.
- Reset, including mid-transaction:
  - State=IDLE, cnt=0, dbg_ack=0, dbg_rdata=0, stats=0.
  - RAM mux returns to CPU immediately (asynchronous) and cpu_stall=0.
  - No spurious write is issued.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: stat_stall_cnt increments each cycle cpu_stall=1; stat_dbg_cnt increments on each GRANT entry. Both 32-bit, saturating at 0xFFFFFFFF, cleared by clr.
- Undefined: both outputs tied to 0 and no counter flops are synthesized.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE, WAIT, GRANT, ACK).
  - default AW/DW.
  - RAM mode encodings (word/half/byte).
- Sub-module dmem_arb_stats: holds the two saturating counters, instantiated only under DMEM_ARB_STATS_EN.
- FSM and mux stay in dmem_arbiter.

Test Plan:
- Idle CPU: dbg_req=1, dbg_addr=0x010, RAM[0x010]=0xDEADBEEF -> dbg_ack at cycle 2, dbg_rdata=0xDEADBEEF, cpu_stall never high.
- Continuous CPU loads with MAXWAIT=4, dbg_req raised -> GRANT after 4 WAIT cycles, cpu_stall=1 for exactly one cycle, ack in cycle 6.
- CPU store to 0x020 (0x12345678) coincident with GRANT -> ram_we=0 that cycle; store lands on the following cycle; readback=0x12345678.
- dbg_req dropped in WAIT after 2 cycles -> return to IDLE, no dbg_ack, no stall.
- clr asserted during GRANT -> outputs reset asynchronously, cpu_stall=0, no ack; a fresh request afterwards completes normally.
- With DMEM_ARB_STATS_EN, 3 debug reads under CPU load -> stat_dbg_cnt=3, stat_stall_cnt=3. Without the macro, both outputs read 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   - arb_state_t : arbiter states (idle, waiting behind CPU, debug grant, ack)
//   - DEF_AW/DEF_DW : default address/data widths
//   - MODE_* : RAM access-size encodings carried on ram_mode
package dmem_arb_pkg;

    localparam int unsigned DEF_AW = 12;
    localparam int unsigned DEF_DW = 32;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GRANT,
        ST_ACK
    } arb_state_t;

endpackage

// File: rtl/dmem_arb_stats.sv
// dmem_arb_stats: two saturating 32-bit event counters for the arbiter.
// Only instantiated when DMEM_ARB_STATS_EN is defined.
// Ports:
//   clk, clr     : clock, asynchronous active-high reset (clears counters)
//   stall        : CPU stalled this cycle
//   grant_entry  : arbiter enters the debug grant state at the next edge
//   stall_cnt    : number of stalled cycles, saturating
//   dbg_cnt      : number of debug grants, saturating
module dmem_arb_stats (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        grant_entry,
    output logic [31:0] stall_cnt,
    output logic [31:0] dbg_cnt
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt <= '0;
            dbg_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (grant_entry && (dbg_cnt != '1)) dbg_cnt <= dbg_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU load/store
// path (priority) and a read-only debug requester. A pending debug request
// waits at most MAXWAIT cycles behind CPU traffic, then takes the port for
// one cycle, stalling the CPU for that cycle if it was accessing memory.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined;
// otherwise stat_* outputs are tied to zero.
// Ports:
//   clk, clr                      : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata/mode    : CPU access request
//   cpu_rdata, cpu_stall          : load data (from RAM), PC-hold request
//   dbg_req, dbg_addr             : debug read request (level, held until ack)
//   dbg_ack, dbg_rdata            : one-cycle ack pulse, registered read data
//   ram_addr/wdata/mode/we        : to RAM (synchronous write)
//   ram_rdata                     : from RAM (asynchronous read)
//   stat_stall_cnt, stat_dbg_cnt  : statistics (feature only)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned MAXWAIT = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [1:0]    cpu_mode,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [1:0]    ram_mode,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic [31:0]   stat_stall_cnt,
    output logic [31:0]   stat_dbg_cnt
);

    localparam int unsigned CW = $clog2(MAXWAIT + 1);

    arb_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          in_grant;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (dbg_req) begin
                    if (cpu_req) begin
                        state_next = ST_WAIT;
                        cnt_next   = CW'(1);
                    end else begin
                        state_next = ST_GRANT;
                    end
                end
            end
            ST_WAIT: begin
                if (!dbg_req) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (!cpu_req || (cnt == CW'(MAXWAIT))) begin
                    state_next = ST_GRANT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_GRANT: state_next = ST_ACK;
            ST_ACK: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Port mux decodes the registered state only, so the asynchronous reset
    // hands the RAM back to the CPU and drops the stall immediately.
    assign in_grant = (state == ST_GRANT);

    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_mode  = cpu_mode;
        ram_we    = cpu_req & cpu_we;
        cpu_stall = 1'b0;
        if (in_grant) begin
            ram_addr  = dbg_addr;
            ram_mode  = MODE_WORD;
            ram_we    = 1'b0;
            cpu_stall = cpu_req;
        end
    end

    assign cpu_rdata = ram_rdata;
    assign dbg_ack   = (state == ST_ACK);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dbg_rdata <= '0;
        end else if (in_grant) begin
            dbg_rdata <= ram_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats u_stats (
        .clk         (clk),
        .clr         (clr),
        .stall       (cpu_stall),
        .grant_entry (state_next == ST_GRANT),
        .stall_cnt   (stat_stall_cnt),
        .dbg_cnt     (stat_dbg_cnt)
    );
`else
    assign stat_stall_cnt = '0;
    assign stat_dbg_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter (MAXWAIT=4).
// A timestamp-based reference model predicts when each debug request is
// granted and acknowledged; a negedge process compares every output each
// cycle. Directed sequences pin latencies and data with literal values.
module tb_dmem_arbiter;

    localparam int AW      = 12;
    localparam int DW      = 32;
    localparam int MAXWAIT = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [1:0]    cpu_mode = 2'b00;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [1:0]    ram_mode;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic [31:0]   stat_stall_cnt, stat_dbg_cnt;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .clr(clr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_mode(cpu_mode),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mode(ram_mode),
        .ram_we(ram_we), .ram_rdata(ram_rdata),
        .stat_stall_cnt(stat_stall_cnt), .stat_dbg_cnt(stat_dbg_cnt)
    );

    always #5 clk = ~clk;

    // RAM environment: word array, async read, sync write.
    logic [31:0] ram    [0:1023];
    logic [31:0] shadow [0:1023];
    assign ram_rdata = ram[ram_addr[11:2]];
    always @(posedge clk) if (ram_we) ram[ram_addr[11:2]] <= ram_wdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: got no dbg_ack, required one within 40 cycles", name);
    endtask

    // Reference model: a request seen at cycle s is granted in the first
    // cycle after the CPU is idle, or after MAXWAIT cycles of waiting,
    // whichever comes first; ack follows the grant cycle.
    int          req_t = 0, grant_t = -100, busy_until = -1;
    bit          waiting = 1'b0;
    logic [31:0] exp_dbg_rdata = '0;
    int unsigned m_stalls = 0, m_grants = 0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            waiting       = 1'b0;
            grant_t       = -100;
            busy_until    = cyc - 1;
            exp_dbg_rdata = '0;
            m_stalls      = 0;
            m_grants      = 0;
        end else begin
            if (cyc == grant_t) begin
                exp_dbg_rdata = shadow[dbg_addr[11:2]];
                if (cpu_req) m_stalls++;
            end else if (cpu_req && cpu_we) begin
                shadow[cpu_addr[11:2]] = cpu_wdata;
            end
            if (waiting) begin
                if (!dbg_req) begin
                    waiting    = 1'b0;
                    busy_until = cyc;
                end else if (!cpu_req || (cyc - req_t >= MAXWAIT)) begin
                    waiting    = 1'b0;
                    grant_t    = cyc + 1;
                    busy_until = cyc + 2;
                    m_grants++;
                end
            end else if (cyc > busy_until && dbg_req) begin
                if (!cpu_req) begin
                    grant_t    = cyc + 1;
                    busy_until = cyc + 2;
                    m_grants++;
                end else begin
                    waiting = 1'b1;
                    req_t   = cyc;
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic        g, a;
        logic [11:0] ea;
        if (!clr) begin
            g  = (cyc == grant_t);
            a  = (cyc == grant_t + 1);
            ea = g ? dbg_addr : cpu_addr;
            check("ram_addr",  32'(ram_addr),  32'(ea));
            check("ram_mode",  32'(ram_mode),  32'(g ? 2'b00 : cpu_mode));
            check("ram_we",    32'(ram_we),    32'(!g && cpu_req && cpu_we));
            if (!g) check("ram_wdata", ram_wdata, cpu_wdata);
            check("cpu_stall", 32'(cpu_stall), 32'(g && cpu_req));
            check("dbg_ack",   32'(dbg_ack),   32'(a));
            check("dbg_rdata", dbg_rdata, exp_dbg_rdata);
            check("cpu_rdata", cpu_rdata, shadow[ea[11:2]]);
        end
    end

    logic last_stall = 1'b0;
    always @(posedge clk) last_stall <= cpu_stall;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    // Issues one debug read from a non-ack cycle; lat counts cycles from the
    // request cycle (0) to the ack cycle. CPU inputs are left untouched.
    task automatic dbg_read(input logic [11:0] a, output int lat, output int stalls,
                            output logic [31:0] data);
        step();
        dbg_addr = a;
        dbg_req  = 1'b1;
        lat      = -1;
        stalls   = 0;
        data     = '0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (cpu_stall) stalls++;
            if (dbg_ack) begin
                lat     = k;
                data    = dbg_rdata;
                dbg_req = 1'b0;
                break;
            end
        end
        if (lat < 0) begin
            dbg_req = 1'b0;
            timeout_fail("dbg_read");
        end
    endtask

    initial begin
        int          lat, stalls, acks;
        logic [31:0] data, v;
        logic [31:0] exp_s;

        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            ram[i] = v;
            shadow[i] = v;
        end
        ram[4]    = 32'hDEADBEEF; shadow[4]    = 32'hDEADBEEF;
        ram[17]   = 32'hA5A50044; shadow[17]   = 32'hA5A50044;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_ack",   32'(dbg_ack),   32'd0);
        check("rst_rdata", dbg_rdata,      32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_sstat", stat_stall_cnt, 32'd0);
        check("rst_dstat", stat_dbg_cnt,   32'd0);
        clr = 1'b0;

        // Idle CPU read
        dbg_read(12'h010, lat, stalls, data);
        check("idle_lat",   32'(lat),    32'd2);
        check("idle_data",  data,        32'hDEADBEEF);
        check("idle_stall", 32'(stalls), 32'd0);

        // Continuous CPU loads
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h100;
        dbg_read(12'h044, lat, stalls, data);
        check("busy_lat",   32'(lat),    32'd6);
        check("busy_stall", 32'(stalls), 32'd1);
        check("busy_data",  data,        32'hA5A50044);
        cpu_idle();
        step();

        // CPU store coincident with GRANT
        dbg_addr = 12'h030; dbg_req = 1'b1;
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 32'h12345678;
        #1;
        check("st_grant_we",    32'(ram_we),    32'd0);
        check("st_grant_stall", 32'(cpu_stall), 32'd1);
        step();
        check("st_ack", 32'(dbg_ack), 32'd1);
        dbg_req = 1'b0;
        #1;
        check("st_retry_we", 32'(ram_we), 32'd1);
        step();
        cpu_idle();
        dbg_read(12'h020, lat, stalls, data);
        check("st_readback", data, 32'h12345678);

        // Abort in WAIT
        step();
        cpu_req = 1'b1; cpu_addr = 12'h0F0;
        dbg_addr = 12'h050; dbg_req = 1'b1;
        step(); step();
        dbg_req = 1'b0;
        acks = 0; stalls = 0;
        repeat (8) begin
            step();
            if (dbg_ack) acks++;
            if (cpu_stall) stalls++;
        end
        check("abort_ack",   32'(acks),   32'd0);
        check("abort_stall", 32'(stalls), 32'd0);
        cpu_idle();

        // Reset during GRANT
        step();
        dbg_addr = 12'h010; dbg_req = 1'b1;
        step();
        cpu_req = 1'b1; cpu_addr = 12'h0A0;
        #1;
        check("rg_stall_pre", 32'(cpu_stall), 32'd1);
        #2;
        clr = 1'b1;
        #1;
        check("rg_stall", 32'(cpu_stall), 32'd0);
        check("rg_ack",   32'(dbg_ack),   32'd0);
        check("rg_we",    32'(ram_we),    32'd0);
        check("rg_addr",  32'(ram_addr),  32'h0A0);
        check("rg_rdata", dbg_rdata,      32'd0);
        dbg_req = 1'b0;
        cpu_idle();
        step();
        #2;
        clr = 1'b0;
        dbg_read(12'h010, lat, stalls, data);
        check("rg_fresh_lat",  32'(lat), 32'd2);
        check("rg_fresh_data", data,     32'hDEADBEEF);

        // Stats: three reads under CPU load from a fresh reset
        step();
        #2; clr = 1'b1;
        step();
        #2; clr = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0C0;
        for (int i = 0; i < 3; i++) dbg_read(12'(16 * i), lat, stalls, data);
        cpu_idle();
        repeat (3) step();
`ifdef DMEM_ARB_STATS_EN
        exp_s = 32'd3;
`else
        exp_s = 32'd0;
`endif
        check("stat_dbg3",   stat_dbg_cnt,   exp_s);
        check("stat_stall3", stat_stall_cnt, exp_s);

        // Randomized traffic at several CPU load levels
        for (int seg = 0; seg < 4; seg++) begin
            int pct;
            pct = (seg == 0) ? 0 : (seg == 1) ? 30 : (seg == 2) ? 70 : 100;
            repeat (800) begin
                step();
                if (!last_stall) begin
                    cpu_req   = ($urandom_range(0, 99) < pct);
                    cpu_we    = ($urandom_range(0, 2) == 0);
                    cpu_addr  = 12'($urandom_range(0, 255));
                    cpu_wdata = $urandom;
                    cpu_mode  = 2'($urandom_range(0, 2));
                end
                if (dbg_req) begin
                    if (dbg_ack) dbg_req = 1'b0;
                    else if ($urandom_range(0, 31) == 0) dbg_req = 1'b0;
                end else if (!dbg_ack && $urandom_range(0, 3) == 0) begin
                    dbg_req  = 1'b1;
                    dbg_addr = 12'($urandom_range(0, 255));
                end
            end
        end
        dbg_req = 1'b0;
        cpu_idle();
        repeat (5) step();
`ifdef DMEM_ARB_STATS_EN
        check("stat_dbg_end",   stat_dbg_cnt,   32'(m_grants));
        check("stat_stall_end", stat_stall_cnt, 32'(m_stalls));
`else
        check("stat_dbg_end",   stat_dbg_cnt,   32'd0);
        check("stat_stall_end", stat_stall_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
